// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller command port between the
// LCD refill reader (fixed-length read bursts, highest priority) and the
// fractal pixel writer (up to WRITE_BURST_LENGTH words per grant).
// Optional build macro SDRAM_ARB_STARVE_GUARD_EN adds a writer starvation
// guard that forces a write grant after STARVE_LIMIT consecutive read grants
// issued while the writer was waiting.
module sdram_port_arbiter #(
  parameter int unsigned READ_BURST_LENGTH  = 8,
  parameter int unsigned WRITE_BURST_LENGTH = 8,
  parameter int unsigned STARVE_LIMIT       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [21:0] rd_addr,
  output logic        rd_grant,
  output logic [31:0] rd_data,
  output logic        rd_data_valid,
  input  logic        wr_req,
  input  logic [21:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic [1:0]  ctl_command,
  output logic [21:0] ctl_address,
  output logic [31:0] ctl_data_write,
  input  logic [31:0] ctl_data_read,
  input  logic        ctl_data_read_valid,
  input  logic        ctl_data_write_done,
  output logic        busy
);

  localparam int unsigned MAX_LEN = (READ_BURST_LENGTH > WRITE_BURST_LENGTH) ?
                                    READ_BURST_LENGTH : WRITE_BURST_LENGTH;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_BURST_LENGTH - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_BURST_LENGTH - 1);

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  // Degenerate lengths would leave a burst with nothing to count.
  if (READ_BURST_LENGTH < 1 || WRITE_BURST_LENGTH < 1 || STARVE_LIMIT < 1) begin : g_param_check
    $error("sdram_port_arbiter: burst lengths and STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [21:0]      addr_q;
  logic [1:0]       cmd_q;
  logic             rd_grant_q;
  logic [31:0]      rd_data_q;
  logic             rd_valid_q;
  logic             busy_q;

  logic             starved;
  logic             grant_rd;
  logic             grant_wr;

  // Grant decision in IDLE; reads win unless the writer is starved.
  always_comb begin
    grant_rd = (state_q == IDLE) && rd_req && !starved;
    grant_wr = (state_q == IDLE) && !grant_rd && wr_req;
  end

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;

  // Saturating count of read grants taken while the writer was waiting.
  always_comb begin
    starve_d = starve_q;
    if (grant_wr) begin
      starve_d = '0;
    end else if (grant_rd && wr_req && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Writer is starved once the limit is reached and it is still asking.
  always_comb begin
    starved = (starve_q == STARVE_MAX) && wr_req;
  end
`else
  // Strict read priority: the writer is never promoted.
  always_comb begin
    starved = 1'b0;
  end
`endif

  // Arbiter FSM with registered command, grant, busy and read-return path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      cmd_q      <= CMD_IDLE;
      rd_grant_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_grant_q <= 1'b0;
      rd_data_q  <= ctl_data_read;
      rd_valid_q <= (state_q == READ) && ctl_data_read_valid;
      case (state_q)
        IDLE: begin
          if (grant_rd) begin
            state_q    <= READ;
            cmd_q      <= CMD_READ;
            busy_q     <= 1'b1;
            addr_q     <= rd_addr;
            cnt_q      <= RD_LAST;
            rd_grant_q <= 1'b1;
          end else if (grant_wr) begin
            state_q <= WRITE;
            cmd_q   <= CMD_WRITE;
            busy_q  <= 1'b1;
            cnt_q   <= WR_LAST;
          end
        end
        READ: begin
          if (ctl_data_read_valid) begin
            if (cnt_q == '0) begin
              state_q <= IDLE;
              cmd_q   <= CMD_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        WRITE: begin
          if (ctl_data_write_done) begin
            if ((cnt_q == '0) || !wr_req) begin
              state_q <= IDLE;
              cmd_q   <= CMD_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cmd_q   <= CMD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write words pass straight through; reads use the latched burst base.
  always_comb begin
    ctl_command    = cmd_q;
    ctl_address    = (state_q == WRITE) ? wr_addr : addr_q;
    ctl_data_write = (state_q == WRITE) ? wr_data : 32'd0;
    wr_ack         = (state_q == WRITE) && ctl_data_write_done;
    rd_grant       = rd_grant_q;
    rd_data        = rd_data_q;
    rd_data_valid  = rd_valid_q;
    busy           = busy_q;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter. Honours SDRAM_ARB_STARVE_GUARD_EN
// when choosing the expected grant order under contention.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_req;
  logic [21:0] rd_addr;
  logic        rd_grant;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        wr_req;
  logic [21:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic [1:0]  ctl_command;
  logic [21:0] ctl_address;
  logic [31:0] ctl_data_write;
  logic [31:0] ctl_data_read;
  logic        ctl_data_read_valid;
  logic        ctl_data_write_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sdram_port_arbiter #(
    .READ_BURST_LENGTH (8),
    .WRITE_BURST_LENGTH(8),
    .STARVE_LIMIT      (4)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .rd_req             (rd_req),
    .rd_addr            (rd_addr),
    .rd_grant           (rd_grant),
    .rd_data            (rd_data),
    .rd_data_valid      (rd_data_valid),
    .wr_req             (wr_req),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .wr_ack             (wr_ack),
    .ctl_command        (ctl_command),
    .ctl_address        (ctl_address),
    .ctl_data_write     (ctl_data_write),
    .ctl_data_read      (ctl_data_read),
    .ctl_data_read_valid(ctl_data_read_valid),
    .ctl_data_write_done(ctl_data_write_done),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant a read at addr, return 8 beats d0..d0+7, check data and close.
  task automatic do_read(input logic [21:0] addr, input logic [31:0] d0, input string tag);
    rd_req  = 1'b1;
    rd_addr = addr;
    step();
    chk({tag, "_grant"}, rd_grant, 1'b1);
    chk({tag, "_cmd"}, ctl_command, 2'd2);
    chk({tag, "_busy"}, busy, 1'b1);
    rd_req  = 1'b0;
    rd_addr = 22'h3FFFFF;
    for (int b = 0; b < 8; b++) begin
      ctl_data_read_valid = 1'b1;
      ctl_data_read       = d0 + 32'(b);
      step();
      chk({tag, "_addr"}, ctl_address, addr);
      chk({tag, "_rgrant_lo"}, rd_grant, 1'b0);
      chk({tag, "_dv"}, rd_data_valid, 1'b1);
      chk({tag, "_data"}, rd_data, d0 + 32'(b));
      chk({tag, "_cmd_run"}, ctl_command, (b < 7) ? 2'd2 : 2'd0);
    end
    ctl_data_read_valid = 1'b0;
    step();
    chk({tag, "_dv_end"}, rd_data_valid, 1'b0);
    chk({tag, "_idle"}, ctl_command, 2'd0);
  endtask

  logic       exp_w [10];
  logic [1:0] exp_cmd;
  int         nack;
  int         total_ack;

  initial begin
    reset_n             = 1'b0;
    rd_req              = 1'b0;
    rd_addr             = '0;
    wr_req              = 1'b0;
    wr_addr             = '0;
    wr_data             = '0;
    ctl_data_read       = '0;
    ctl_data_read_valid = 1'b0;
    ctl_data_write_done = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_cmd", ctl_command, 2'd0);
    chk("rst_addr", ctl_address, 22'd0);
    chk("rst_wdata", ctl_data_write, 32'd0);
    chk("rst_grant", rd_grant, 1'b0);
    chk("rst_rdata", rd_data, 32'd0);
    chk("rst_dv", rd_data_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", wr_ack, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Single read burst
    do_read(22'h00100, 32'hA0, "rd1");

    // Write stream of 10 words: 8 in the first grant, 2 in the second
    wr_req  = 1'b1;
    wr_addr = 22'd0;
    wr_data = 32'hD000;
    step();
    chk("wr1_cmd", ctl_command, 2'd1);
    chk("wr1_ack_idle", wr_ack, 1'b0);
    for (int a = 0; a < 8; a++) begin
      wr_addr             = 22'(a);
      wr_data             = 32'hD000 + 32'(a);
      ctl_data_write_done = 1'b1;
      #1;
      chk("wr1_ack", wr_ack, 1'b1);
      chk("wr1_addr", ctl_address, 22'(a));
      chk("wr1_data", ctl_data_write, 32'hD000 + 32'(a));
      step();
      chk("wr1_cmd_run", ctl_command, (a < 7) ? 2'd1 : 2'd0);
    end
    ctl_data_write_done = 1'b0;
    wr_addr             = 22'd8;
    wr_data             = 32'hD008;
    #1;
    chk("wr_gap_ack", wr_ack, 1'b0);
    chk("wr_gap_busy", busy, 1'b0);
    step();
    chk("wr2_cmd", ctl_command, 2'd1);
    step();
    chk("wr2_wait_cmd", ctl_command, 2'd1);
    ctl_data_write_done = 1'b1;
    #1;
    chk("wr2_ack8", wr_ack, 1'b1);
    chk("wr2_addr8", ctl_address, 22'd8);
    step();
    chk("wr2_cmd_run", ctl_command, 2'd1);
    wr_addr = 22'd9;
    wr_data = 32'hD009;
    wr_req  = 1'b0;
    #1;
    chk("wr2_ack9", wr_ack, 1'b1);
    chk("wr2_data9", ctl_data_write, 32'hD009);
    step();
    ctl_data_write_done = 1'b0;
    chk("wr2_close_cmd", ctl_command, 2'd0);
    chk("wr2_close_busy", busy, 1'b0);
    step();
    chk("wr_stay_idle", ctl_command, 2'd0);

    // Contention: both requests held
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    for (int g = 0; g < 10; g++) exp_w[g] = (g == 4) || (g == 9);
`else
    for (int g = 0; g < 10; g++) exp_w[g] = 1'b0;
`endif
    total_ack = 0;
    rd_req    = 1'b1;
    rd_addr   = 22'h00200;
    wr_req    = 1'b1;
    wr_addr   = 22'h00040;
    wr_data   = 32'hC0DE;
    for (int g = 0; g < 10; g++) begin
      step();
      exp_cmd = exp_w[g] ? 2'd1 : 2'd2;
      chk("cont_grant_cmd", ctl_command, exp_cmd);
      chk("cont_rd_grant", rd_grant, !exp_w[g]);
      if (ctl_command == 2'd2) begin
        for (int b = 0; b < 8; b++) begin
          ctl_data_read_valid = 1'b1;
          ctl_data_read       = 32'(g * 16 + b);
          step();
        end
        ctl_data_read_valid = 1'b0;
      end else if (ctl_command == 2'd1) begin
        ctl_data_write_done = 1'b1;
        nack = 0;
        for (int k = 0; k < 20; k++) begin
          #0;
          if (wr_ack) nack++;
          step();
          if (ctl_command == 2'd0) break;
        end
        ctl_data_write_done = 1'b0;
        total_ack += nack;
        chk("cont_wr_acks", nack, 8);
      end
      chk("cont_close", ctl_command, 2'd0);
    end
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    chk("cont_total_ack", total_ack, 16);
`else
    chk("cont_total_ack", total_ack, 0);
`endif
    rd_req = 1'b0;
    wr_req = 1'b0;
    step();
    chk("cont_end_idle", ctl_command, 2'd0);

    // Stray strobes in IDLE
    ctl_data_read_valid = 1'b1;
    ctl_data_read       = 32'h55;
    ctl_data_write_done = 1'b1;
    #1;
    chk("stray_ack", wr_ack, 1'b0);
    step();
    ctl_data_read_valid = 1'b0;
    ctl_data_write_done = 1'b0;
    chk("stray_dv", rd_data_valid, 1'b0);
    chk("stray_busy", busy, 1'b0);
    chk("stray_cmd", ctl_command, 2'd0);

    // Reset mid-read after three beats
    rd_req  = 1'b1;
    rd_addr = 22'h002A0;
    step();
    chk("mid_grant", rd_grant, 1'b1);
    rd_req = 1'b0;
    for (int b = 0; b < 3; b++) begin
      ctl_data_read_valid = 1'b1;
      ctl_data_read       = 32'hE0 + 32'(b);
      step();
    end
    chk("mid_busy_pre", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmd", ctl_command, 2'd0);
    chk("mid_rst_addr", ctl_address, 22'd0);
    chk("mid_rst_rdata", rd_data, 32'd0);
    chk("mid_rst_dv", rd_data_valid, 1'b0);
    chk("mid_rst_grant", rd_grant, 1'b0);
    ctl_data_read_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    do_read(22'h00300, 32'hB0, "rd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
